shift_reg_univ: RTL and testbench

Parametrised universal shift register: the successor to our fixed 8-bit serial/parallel-load register. It adds configurable width, bidirectional shift, rotate, arithmetic shift and clear, plus a registered serial output and a shift counter with a completion pulse. It sits between parallel datapaths and bit-serial links as a serializer/deserializer, and also serves as a general-purpose shifter in the lab designs.

---
 rtl/shift_reg_univ.sv | 111 +++++++++++
 tb/tb_shift_reg_univ.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_univ.sv
// Universal shift register: load, shift, rotate, arithmetic shift, clear.
// Registered serial output and saturating shift counter with done pulse.
module shift_reg_univ #(
   parameter int WIDTH = 8,
   parameter logic [WIDTH-1:0] INIT = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [2:0]                   mode,
   input  logic                         s_in,
   input  logic [WIDTH-1:0]             p_in,
   output logic [WIDTH-1:0]             Q,
   output logic                         s_out,
   output logic [$clog2(WIDTH+1)-1:0]   cnt,
   output logic                         done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CMAX  = CW'(WIDTH);
   localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE   = CW'(1);

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SHR  = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_ROR  = 3'b011;
   localparam logic [2:0] M_ROL  = 3'b100;
   localparam logic [2:0] M_LOAD = 3'b101;
   localparam logic [2:0] M_ASR  = 3'b110;
   localparam logic [2:0] M_CLR  = 3'b111;

   // Declaration initialisers give the reset state at power-up
   logic [WIDTH-1:0] q_r    = INIT;
   logic             so_r   = 1'b0;
   logic [CW-1:0]    cnt_r  = '0;
   logic             done_r = 1'b0;

   logic [WIDTH-1:0] q_nxt;
   logic             so_nxt;
   logic             is_shift;
   logic             cnt_zero;

   always_comb begin
      q_nxt    = q_r;
      so_nxt   = so_r;
      is_shift = 1'b0;
      cnt_zero = 1'b0;
      case (mode)
         M_SHR: begin
            q_nxt    = {s_in, q_r[WIDTH-1:1]};
            so_nxt   = q_r[0];
            is_shift = 1'b1;
         end
         M_SHL: begin
            q_nxt    = {q_r[WIDTH-2:0], s_in};
            so_nxt   = q_r[WIDTH-1];
            is_shift = 1'b1;
         end
         M_ROR: begin
            q_nxt    = {q_r[0], q_r[WIDTH-1:1]};
            so_nxt   = q_r[0];
            is_shift = 1'b1;
         end
         M_ROL: begin
            q_nxt    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            so_nxt   = q_r[WIDTH-1];
            is_shift = 1'b1;
         end
         M_LOAD: begin
            q_nxt    = p_in;
            cnt_zero = 1'b1;
         end
         M_ASR: begin
            q_nxt    = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
            so_nxt   = q_r[0];
            is_shift = 1'b1;
         end
         M_CLR: begin
            q_nxt    = '0;
            so_nxt   = 1'b0;
            cnt_zero = 1'b1;
         end
         M_HOLD: ;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_r    <= INIT;
         so_r   <= 1'b0;
         cnt_r  <= '0;
         done_r <= 1'b0;
      end else begin
         q_r    <= q_nxt;
         so_r   <= so_nxt;
         // Pulse only on the WIDTH-1 -> WIDTH transition, never while saturated
         done_r <= is_shift && (cnt_r == CLAST);
         if (cnt_zero)
            cnt_r <= '0;
         else if (is_shift && (cnt_r != CMAX))
            cnt_r <= cnt_r + ONE;
      end
   end

   assign Q     = q_r;
   assign s_out = so_r;
   assign cnt   = cnt_r;
   assign done  = done_r;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ at WIDTH 8, 2 and 32 driven in lockstep.
// Reference model tracks each register as an integer value.
module tb_shift_reg_univ;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  mode = 3'b000;
   logic        s_in = 1'b0;
   logic [7:0]  p8 = '0;
   logic [1:0]  p2 = '0;
   logic [31:0] p32 = '0;

   logic [7:0]  q8;
   logic        so8;
   logic [3:0]  c8;
   logic        d8;
   logic [1:0]  q2;
   logic        so2;
   logic [1:0]  c2;
   logic        d2;
   logic [31:0] q32;
   logic        so32;
   logic [5:0]  c32;
   logic        d32;

   int n_cmp = 0;
   int n_fail = 0;

   longint ww[3] = '{8, 2, 32};
   longint mi[3] = '{64'hA5, 64'h2, 64'hDEADBEEF};
   longint mq[3] = '{64'hA5, 64'h2, 64'hDEADBEEF};
   bit     ms[3] = '{1'b0, 1'b0, 1'b0};
   longint mc[3] = '{0, 0, 0};
   bit     md[3] = '{1'b0, 1'b0, 1'b0};

   shift_reg_univ #(.WIDTH(8), .INIT(8'hA5)) u8 (
      .clk(clk), .rst(rst), .mode(mode), .s_in(s_in), .p_in(p8),
      .Q(q8), .s_out(so8), .cnt(c8), .done(d8)
   );
   shift_reg_univ #(.WIDTH(2), .INIT(2'b10)) u2 (
      .clk(clk), .rst(rst), .mode(mode), .s_in(s_in), .p_in(p2),
      .Q(q2), .s_out(so2), .cnt(c2), .done(d2)
   );
   shift_reg_univ #(.WIDTH(32), .INIT(32'hDEADBEEF)) u32 (
      .clk(clk), .rst(rst), .mode(mode), .s_in(s_in), .p_in(p32),
      .Q(q32), .s_out(so32), .cnt(c32), .done(d32)
   );

   always #5 clk = ~clk;

   // Drive one edge of stimulus and advance the model; outputs sampled 1ns after
   task automatic step(input bit r, input logic [2:0] m,
                       input bit s, input logic [31:0] p);
      @(negedge clk);
      rst = r; mode = m; s_in = s;
      p8 = p[7:0]; p2 = p[1:0]; p32 = p;
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         longint w, msk, q, top;
         bit sh, zr;
         w = ww[k];
         msk = (64'd1 << w) - 1;
         q = mq[k];
         top = (q >> (w - 1)) & 1;
         sh = 1'b0;
         zr = 1'b0;
         if (r) begin
            mq[k] = mi[k]; ms[k] = 1'b0; mc[k] = 0; md[k] = 1'b0;
         end else begin
            case (m)
               3'b001: begin ms[k] = q[0]; mq[k] = (q >> 1) | (longint'(s) << (w - 1)); sh = 1; end
               3'b010: begin ms[k] = top[0]; mq[k] = ((q << 1) | longint'(s)) & msk; sh = 1; end
               3'b011: begin ms[k] = q[0]; mq[k] = (q >> 1) | ((q & 1) << (w - 1)); sh = 1; end
               3'b100: begin ms[k] = top[0]; mq[k] = ((q << 1) | top) & msk; sh = 1; end
               3'b101: begin mq[k] = longint'(p) & msk; zr = 1; end
               3'b110: begin ms[k] = q[0]; mq[k] = (q >> 1) | (top << (w - 1)); sh = 1; end
               3'b111: begin mq[k] = 0; ms[k] = 1'b0; zr = 1; end
               default: ;
            endcase
            md[k] = sh && (mc[k] == w - 1);
            if (zr) mc[k] = 0;
            else if (sh && mc[k] < w) mc[k] = mc[k] + 1;
         end
      end
      #1;
   endtask

   task automatic test_reset;
      #1;
      n_cmp++;
      if (q8 !== 8'hA5) begin n_fail++; $display("FAIL powerup_q8: got %h expected a5", q8); end
      step(1, 3'b000, 0, 0);
      n_cmp++;
      if (q8 !== 8'hA5) begin n_fail++; $display("FAIL reset_q8: got %h expected a5", q8); end
      n_cmp++;
      if (c8 !== 4'd0 || d8 !== 1'b0 || so8 !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags: cnt=%0d done=%b s_out=%b expected 0 0 0", c8, d8, so8);
      end
      n_cmp++;
      if (q2 !== 2'b10 || q32 !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL reset_init: q2=%b q32=%h expected 10 deadbeef", q2, q32);
      end
      step(0, 3'b101, 0, 32'h3C);
      n_cmp++;
      if (q8 !== 8'h3C || c8 !== 4'd0) begin
         n_fail++; $display("FAIL load_3c: Q=%h cnt=%0d expected 3c 0", q8, c8);
      end
   endtask

   task automatic test_serialize_right;
      logic [7:0] exp_so;
      exp_so = 8'b1001_0110;
      step(0, 3'b101, 0, 32'h96);
      for (int i = 0; i < 8; i++) begin
         step(0, 3'b001, 0, 0);
         n_cmp++;
         if (so8 !== exp_so[i] || c8 !== 4'(i + 1) || d8 !== (i == 7)) begin
            n_fail++;
            $display("FAIL ser_right[%0d]: s_out=%b cnt=%0d done=%b expected %b %0d %b",
                     i, so8, c8, d8, exp_so[i], i + 1, i == 7);
         end
      end
      n_cmp++;
      if (q8 !== 8'h00) begin n_fail++; $display("FAIL ser_right_q: got %h expected 00", q8); end
      step(0, 3'b001, 0, 0);
      n_cmp++;
      if (c8 !== 4'd8 || d8 !== 1'b0) begin
         n_fail++; $display("FAIL ser_saturate: cnt=%0d done=%b expected 8 0", c8, d8);
      end
   endtask

   task automatic test_deserialize_left;
      logic [7:0] bits;
      bits = 8'b1101_0001;
      step(0, 3'b111, 0, 0);
      for (int i = 0; i < 8; i++) begin
         step(0, 3'b010, bits[7 - i], 0);
         n_cmp++;
         if (d8 !== (i == 7)) begin
            n_fail++; $display("FAIL deser_done[%0d]: got %b expected %b", i, d8, i == 7);
         end
      end
      n_cmp++;
      if (q8 !== 8'hD1) begin n_fail++; $display("FAIL deser_q: got %h expected d1", q8); end
   endtask

   task automatic test_rotate_ashift;
      step(0, 3'b101, 0, 32'h81);
      step(0, 3'b011, 0, 0);
      n_cmp++;
      if (q8 !== 8'hC0 || so8 !== 1'b1) begin
         n_fail++; $display("FAIL ror: Q=%h s_out=%b expected c0 1", q8, so8);
      end
      step(0, 3'b100, 0, 0);
      n_cmp++;
      if (q8 !== 8'h81) begin n_fail++; $display("FAIL rol: got %h expected 81", q8); end
      step(0, 3'b101, 0, 32'hF0);
      step(0, 3'b110, 0, 0);
      n_cmp++;
      if (q8 !== 8'hF8 || so8 !== 1'b0) begin
         n_fail++; $display("FAIL asr: Q=%h s_out=%b expected f8 0", q8, so8);
      end
   endtask

   task automatic test_hold_clear;
      logic [7:0] frozen;
      step(0, 3'b101, 0, 32'h5A);
      for (int i = 0; i < 3; i++) step(0, 3'b010, 1, 0);
      frozen = 8'hD7;
      for (int i = 0; i < 5; i++) begin
         step(0, 3'b000, 0, 32'hFF);
         n_cmp++;
         if (q8 !== frozen || c8 !== 4'd3) begin
            n_fail++; $display("FAIL hold[%0d]: Q=%h cnt=%0d expected %h 3", i, q8, c8, frozen);
         end
      end
      step(0, 3'b111, 1, 0);
      n_cmp++;
      if (q8 !== 8'h00 || c8 !== 4'd0 || so8 !== 1'b0) begin
         n_fail++; $display("FAIL clear: Q=%h cnt=%0d s_out=%b expected 00 0 0", q8, c8, so8);
      end
   endtask

   task automatic test_reset_midframe;
      step(0, 3'b101, 0, 32'h12);
      for (int i = 0; i < 5; i++) step(0, 3'b001, 1, 0);
      step(1, 3'b001, 1, 0);
      n_cmp++;
      if (q8 !== 8'hA5 || c8 !== 4'd0 || d8 !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid: Q=%h cnt=%0d done=%b expected a5 0 0", q8, c8, d8);
      end
      step(0, 3'b001, 0, 0);
      n_cmp++;
      if (c8 !== 4'd1) begin n_fail++; $display("FAIL rst_resume: cnt=%0d expected 1", c8); end
   endtask

   task automatic test_width_sweep;
      step(0, 3'b101, 0, 32'hCAFE_F00D);
      for (int i = 0; i < 34; i++) begin
         step(0, 3'b001, 0, 0);
         n_cmp++;
         if (d2 !== (i == 1) || d32 !== (i == 31)) begin
            n_fail++; $display("FAIL sweep_done[%0d]: d2=%b d32=%b expected %b %b",
                               i, d2, d32, i == 1, i == 31);
         end
      end
      n_cmp++;
      if (c2 !== 2'd2 || c32 !== 6'd32 || q32 !== 32'h0) begin
         n_fail++; $display("FAIL sweep_end: c2=%0d c32=%0d q32=%h expected 2 32 0", c2, c32, q32);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 600; i++) begin
         bit r;
         r = ($urandom_range(0, 49) == 0);
         step(r, 3'($urandom_range(0, 7)), 1'($urandom), $urandom);
         n_cmp++;
         if (q8 !== 8'(mq[0]) || so8 !== ms[0] || c8 !== 4'(mc[0]) || d8 !== md[0]) begin
            n_fail++; $display("FAIL rand8[%0d]: Q=%h s=%b c=%0d d=%b expected %h %b %0d %b",
                               i, q8, so8, c8, d8, 8'(mq[0]), ms[0], mc[0], md[0]);
         end
         n_cmp++;
         if (q2 !== 2'(mq[1]) || so2 !== ms[1] || c2 !== 2'(mc[1]) || d2 !== md[1]) begin
            n_fail++; $display("FAIL rand2[%0d]: Q=%b s=%b c=%0d d=%b expected %b %b %0d %b",
                               i, q2, so2, c2, d2, 2'(mq[1]), ms[1], mc[1], md[1]);
         end
         n_cmp++;
         if (q32 !== 32'(mq[2]) || so32 !== ms[2] || c32 !== 6'(mc[2]) || d32 !== md[2]) begin
            n_fail++; $display("FAIL rand32[%0d]: Q=%h s=%b c=%0d d=%b expected %h %b %0d %b",
                               i, q32, so32, c32, d32, 32'(mq[2]), ms[2], mc[2], md[2]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_serialize_right();
      test_deserialize_left();
      test_rotate_ashift();
      test_hold_clear();
      test_reset_midframe();
      test_width_sweep();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
